syn_mem_arbiter: RTL

Round-robin arbiter that shares one single-port synaptic weight memory between `NREQ` synaptic-control lanes. It grants at most one read per cycle, drives the memory read port, and returns read data to the granting lane with a one-hot response strobe after the fixed memory latency. It sits between the lane controllers and the weight SRAM, and replaces the direct lane-to-memory connection when lanes share storage.

---
 rtl/syn_mem_arbiter_pkg.sv | 40 ++++
 rtl/syn_mem_arbiter_rr_pick.sv | 54 +++++
 rtl/syn_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/syn_mem_arbiter_pkg.sv
// Shared defaults, pointer-update decision type and the reference
// round-robin first-requester function for the weight memory arbiter.
package syn_mem_arbiter_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned ADDRWID_DEF   = 7;
    localparam int unsigned WID_DEF       = 8;
    localparam int unsigned RD_LAT_DEF    = 1;
    localparam int unsigned BURST_MAX_DEF = 8;

    // Widest lane vector rr_first can handle; lane counts above this are unsupported.
    localparam int unsigned RR_MAXW = 32;

    typedef logic [RR_MAXW-1:0] rr_vec_t;

    // What happens to the priority pointer at the end of a cycle.
    typedef enum logic [1:0] {
        UPD_HOLD    = 2'd0,   // no grant: pointer holds, burst ends
        UPD_LOCK    = 2'd1,   // locked lane keeps top priority
        UPD_ADVANCE = 2'd2    // move past the granted lane
    } ptr_upd_e;

    // One-hot first requester scanning ptr, ptr+1, ... modulo n.
    function automatic rr_vec_t rr_first(rr_vec_t req, int unsigned ptr, int unsigned n);
        rr_vec_t res;
        logic    found;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAXW; k++) begin
            if (k < n) begin
                if (!found && req[5'((ptr + k) % n)]) begin
                    res[5'((ptr + k) % n)] = 1'b1;
                    found                  = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/syn_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the pointer lane is
// bit 0, find the lowest set bit, then map that offset back to a lane.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PTRW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PTRW-1:0] o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic [PTRW-1:0] w_off;
    logic            w_any;
    logic [PTRW-1:0] w_idx;

    function automatic logic [PTRW-1:0] lane_of(logic [PTRW-1:0] p, int unsigned k);
        return PTRW'((32'(p) + k) % NREQ);
    endfunction

    // Rotate requests so the highest-priority lane lands on bit 0.
    always_comb begin
        w_rot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_rot[PTRW'(k)] = i_req[lane_of(i_ptr, k)];
        end
    end

    // Lowest set bit of the rotated vector; scanning downwards lets the lowest win.
    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (w_rot[PTRW'(k - 1)]) begin
                w_any = 1'b1;
                w_off = PTRW'(k - 1);
            end
        end
    end

    // Undo the rotation and form the one-hot grant.
    always_comb begin
        w_idx = lane_of(i_ptr, 32'(w_off));
        o_gnt = '0;
        if (w_any) begin
            o_gnt[w_idx] = 1'b1;
        end
        o_idx = w_idx;
        o_any = w_any;
    end

endmodule

// File: rtl/syn_mem_arbiter.sv
// Round-robin arbiter sharing one single-port weight memory between lanes.
// Grants one read per cycle, drives the memory read port and returns data
// to the granted lane with a one-hot strobe after the memory read latency.
module syn_mem_arbiter
    import syn_mem_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned ADDRWID   = ADDRWID_DEF,
    parameter int unsigned WID       = WID_DEF,
    parameter int unsigned RD_LAT    = RD_LAT_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_ren,
    input  logic [NREQ*ADDRWID-1:0]   req_raddr,
    input  logic [NREQ-1:0]           req_lock,
    output logic [NREQ-1:0]           req_gnt,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [WID-1:0]            rsp_data,
    output logic                      mem_ren,
    output logic [ADDRWID-1:0]        mem_raddr,
    input  logic [WID-1:0]            mem_rdata
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = $clog2(BURST_MAX) + 1;

    logic [PTRW-1:0] r_ptr;
    logic [CNTW-1:0] r_burst;
    logic [PTRW-1:0] w_ptr_nxt;
    logic [CNTW-1:0] w_burst_nxt;
    ptr_upd_e        w_upd;

    logic [NREQ-1:0] w_gnt;
    logic [PTRW-1:0] w_idx;
    logic            w_any;

    // One-hot lane per stage; a zero entry means no read in flight there.
    logic [NREQ-1:0] r_tag [RD_LAT];

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .i_req (req_ren),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Pointer and burst counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_burst <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    // Decide how the pointer moves: lock keeps priority until the burst cap.
    always_comb begin
        w_upd = UPD_HOLD;
        if (w_any) begin
            if (req_lock[w_idx] && (r_burst < CNTW'(BURST_MAX - 1))) begin
                w_upd = UPD_LOCK;
            end else begin
                w_upd = UPD_ADVANCE;
            end
        end
    end

    // Next pointer / burst count from the update decision.
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = '0;
        unique case (w_upd)
            UPD_LOCK: begin
                w_ptr_nxt   = w_idx;
                w_burst_nxt = r_burst + 1'b1;
            end
            UPD_ADVANCE: begin
                w_ptr_nxt = (w_idx == PTRW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
            default: begin
                w_ptr_nxt = r_ptr;
            end
        endcase
    end

    // Grant, memory enable and address mux (address is zero when idle).
    always_comb begin
        req_gnt   = w_gnt;
        mem_ren   = w_any;
        mem_raddr = '0;
        if (w_any) begin
            mem_raddr = req_raddr[w_idx*ADDRWID +: ADDRWID];
        end
    end

    // Tag shift register tracking which lane owns each in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= mem_ren ? w_gnt : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign rsp_valid = r_tag[RD_LAT-1];
    assign rsp_data  = mem_rdata;

    // Picker must agree with the package reference function.
    always_comb begin
        assert (RR_MAXW'(w_gnt) == rr_first(RR_MAXW'(req_ren), 32'(r_ptr), NREQ));
    end

endmodule
